// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: controller state
// encoding and the iteration-counter width helper.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Counter must hold WIDTH itself, so it needs clog2(WIDTH+1) bits.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_ctrl.sv
// Controller FSM for seq_multiplier: sequences IDLE -> RUN -> FIX and issues
// the datapath strobes plus the busy/done handshake.
module seq_multiplier_ctrl
  import seq_multiplier_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_mplr_lsb,
  input  logic i_mplr_rest_zero,
  input  logic i_count_last,
  output logic o_load,
  output logic o_add,
  output logic o_shift,
  output logic o_fix,
  output logic o_busy,
  output logic o_done
);

  state_t r_state;
  logic   w_finish;

  // Leave RUN after this iteration if the counter expires or nothing is left to add.
  assign w_finish = i_count_last || (EARLY_EXIT && i_mplr_rest_zero);

  assign o_load  = (r_state == IDLE) && i_start;
  assign o_shift = (r_state == RUN);
  assign o_add   = o_shift && i_mplr_lsb;
  assign o_fix   = (r_state == FIX);

  // NOTE: state and registered outputs use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= RUN;
            o_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (w_finish) r_state <= FIX;
        end
        FIX: begin
          r_state <= IDLE;
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle signed/unsigned shift-add multiplier behind a start/done handshake.
// Operates on magnitudes and applies the sign once in the FIX cycle.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   inA,
  input  logic [WIDTH-1:0]   inB,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int             CW         = cnt_width(WIDTH);
  localparam logic [CW-1:0]  COUNT_INIT = CW'(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [CW-1:0]      r_count;
  logic               r_neg;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_load;
  logic             w_add;
  logic             w_shift;
  logic             w_fix;
  logic             w_mplr_rest_zero;
  logic             w_count_last;

  // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
  assign w_mag_a = (is_signed && inA[WIDTH-1]) ? -inA : inA;
  assign w_mag_b = (is_signed && inB[WIDTH-1]) ? -inB : inB;

  assign w_mplr_rest_zero = (r_mplr[WIDTH-1:1] == '0);
  assign w_count_last     = (r_count == CW'(1));

  seq_multiplier_ctrl #(
    .EARLY_EXIT(EARLY_EXIT)
  ) u_ctrl (
    .clk              (clk),
    .rst_n            (reset),
    .i_start          (start),
    .i_mplr_lsb       (r_mplr[0]),
    .i_mplr_rest_zero (w_mplr_rest_zero),
    .i_count_last     (w_count_last),
    .o_load           (w_load),
    .o_add            (w_add),
    .o_shift          (w_shift),
    .o_fix            (w_fix),
    .o_busy           (busy),
    .o_done           (done)
  );

  // NOTE: every datapath register is reset so an aborted operation leaves no residue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_count <= '0;
      r_neg   <= 1'b0;
      product <= '0;
    end else begin
      if (w_load) begin
        r_acc   <= '0;
        r_mcand <= {{WIDTH{1'b0}}, w_mag_a};
        r_mplr  <= w_mag_b;
        r_count <= COUNT_INIT;
        r_neg   <= is_signed && (inA[WIDTH-1] ^ inB[WIDTH-1]);
      end else if (w_shift) begin
        if (w_add) r_acc <= r_acc + r_mcand;
        r_mcand <= r_mcand << 1;
        r_mplr  <= r_mplr >> 1;
        r_count <= r_count - CW'(1);
      end
      // Negating a zero accumulator yields zero, so -x*0 never produces a stray sign.
      if (w_fix) product <= r_neg ? -r_acc : r_acc;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH=8) with one instance
// using early exit and one always running WIDTH iterations.
module tb_seq_multiplier;

  logic        clk;
  logic        reset;
  logic        start_e, start_n;
  logic        sgn;
  logic [7:0]  a, b;
  logic [15:0] prod_e, prod_n;
  logic        busy_e, busy_n, done_e, done_n;

  logic        sel_nx;
  logic [15:0] prod_s;
  logic        busy_s, done_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    int          lat_e;
  } vec_t;

  vec_t vecs[11];

  seq_multiplier #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e (
    .clk(clk), .reset(reset), .start(start_e), .is_signed(sgn),
    .inA(a), .inB(b), .product(prod_e), .busy(busy_e), .done(done_e)
  );

  seq_multiplier #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_n (
    .clk(clk), .reset(reset), .start(start_n), .is_signed(sgn),
    .inA(a), .inB(b), .product(prod_n), .busy(busy_n), .done(done_n)
  );

  assign prod_s = sel_nx ? prod_n : prod_e;
  assign busy_s = sel_nx ? busy_n : busy_e;
  assign done_s = sel_nx ? done_n : done_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel_nx) start_n = v;
    else        start_e = v;
  endtask

  // Starts an operation just after a clock edge and waits (bounded) for done.
  // disturb re-pulses start with other operands two cycles into RUN.
  task automatic do_op(input logic s, input logic [7:0] opa, input logic [7:0] opb,
                       input bit disturb, output logic [15:0] res, output int lat,
                       output logic busy_ok);
    bit got;
    sgn = s; a = opa; b = opb;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    busy_ok = busy_s;
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      if (disturb && lat == 2) begin
        set_start(1'b1); a = 8'hFF; b = 8'hFF; sgn = ~s;
      end
      if (disturb && lat == 3) set_start(1'b0);
      @(posedge clk); #1;
      lat++;
      if (done_s) begin
        got = 1;
        if (busy_s) busy_ok = 1'b0;
      end else if (!busy_s) begin
        busy_ok = 1'b0;
      end
    end
    set_start(1'b0);
    if (!got) begin
      errors++;
      $display("FAIL timeout: done not seen within 40 cycles (got none, expected pulse)");
    end
    res = prod_s;
  endtask

  initial begin
    logic [15:0] res;
    logic [15:0] held;
    int          lat;
    logic        busy_ok;
    bit          got;
    logic        stray;

    vecs[0]  = '{"u13x11",     1'b0, 8'd13,  8'd11,  16'h008F, 5};
    vecs[1]  = '{"s-3x5",      1'b1, 8'hFD,  8'h05,  16'hFFF1, 4};
    vecs[2]  = '{"u253x5",     1'b0, 8'hFD,  8'h05,  16'h04F1, 4};
    vecs[3]  = '{"s80x80",     1'b1, 8'h80,  8'h80,  16'h4000, 9};
    vecs[4]  = '{"uFFxFF",     1'b0, 8'hFF,  8'hFF,  16'hFE01, 9};
    vecs[5]  = '{"s7Fx0",      1'b1, 8'h7F,  8'h00,  16'h0000, 2};
    vecs[6]  = '{"s-5x0",      1'b1, 8'hFB,  8'h00,  16'h0000, 2};
    vecs[7]  = '{"s7x-2",      1'b1, 8'h07,  8'hFE,  16'hFFF2, 3};
    vecs[8]  = '{"s-128x1",    1'b1, 8'h80,  8'h01,  16'hFF80, 2};
    vecs[9]  = '{"u0xFF",      1'b0, 8'h00,  8'hFF,  16'h0000, 9};
    vecs[10] = '{"s7Fx7F",     1'b1, 8'h7F,  8'h7F,  16'h3F01, 8};

    reset = 1'b0; start_e = 1'b0; start_n = 1'b0; sgn = 1'b0; a = '0; b = '0; sel_nx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_product", {16'd0, prod_e}, 32'd0);
    check("reset_busy",    {31'd0, busy_e}, 32'd0);
    check("reset_done",    {31'd0, done_e}, 32'd0);
    check("reset_product_nx", {16'd0, prod_n}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Table: each vector on the early-exit instance, then on the fixed-latency one.
    for (int i = 0; i < 11; i++) begin
      sel_nx = 1'b0;
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0, res, lat, busy_ok);
      check({vecs[i].name, "_prod"}, {16'd0, res}, {16'd0, vecs[i].exp});
      check({vecs[i].name, "_lat"},  lat, vecs[i].lat_e);
      check({vecs[i].name, "_busy"}, {31'd0, busy_ok}, 32'd1);
      sel_nx = 1'b1;
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0, res, lat, busy_ok);
      check({vecs[i].name, "_prod_nx"}, {16'd0, res}, {16'd0, vecs[i].exp});
      check({vecs[i].name, "_lat_nx"},  lat, 9);
    end
    sel_nx = 1'b0;

    // Product holds between done pulses.
    do_op(1'b0, 8'd13, 8'd11, 1'b0, res, lat, busy_ok);
    repeat (3) @(posedge clk);
    #1;
    check("hold_product", {16'd0, prod_e}, 32'h008F);

    // Start re-pulsed mid-RUN with new operands is ignored.
    do_op(1'b1, 8'hFD, 8'h05, 1'b1, res, lat, busy_ok);
    check("midrun_prod", {16'd0, res}, 32'h0000FFF1);
    check("midrun_lat",  lat, 4);
    @(posedge clk); #1;
    check("midrun_no_restart", {31'd0, busy_e}, 32'd0);

    // Start held through done: second op accepted in the done cycle.
    sgn = 1'b1; a = 8'hFD; b = 8'h05; start_e = 1'b1;
    @(posedge clk); #1;
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (done_e) got = 1;
    end
    check("b2b_first_prod", {16'd0, prod_e}, 32'h0000FFF1);
    check("b2b_first_lat",  lat, 4);
    sgn = 1'b0; a = 8'd13; b = 8'd11;
    @(posedge clk); #1;
    start_e = 1'b0;
    check("b2b_second_busy", {31'd0, busy_e}, 32'd1);
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (done_e) got = 1;
    end
    check("b2b_second_prod", {16'd0, prod_e}, 32'h008F);
    check("b2b_second_lat",  lat, 5);

    // Asynchronous reset in the middle of RUN.
    @(posedge clk); #1;
    sgn = 1'b0; a = 8'hFF; b = 8'hFF; start_e = 1'b1;
    @(posedge clk); #1;
    start_e = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_product", {16'd0, prod_e}, 32'd0);
    check("arst_busy",    {31'd0, busy_e}, 32'd0);
    check("arst_done",    {31'd0, done_e}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done_e || busy_e) stray = 1'b1;
    end
    check("arst_no_stray_done", {31'd0, stray}, 32'd0);
    do_op(1'b1, 8'h07, 8'hFE, 1'b0, res, lat, busy_ok);
    check("arst_next_prod", {16'd0, res}, 32'h0000FFF2);
    check("arst_next_lat",  lat, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
